// File: rtl/otter_dmem_arbiter_pkg.sv
// Shared types and constants for the OTTER data-port arbiter.
package otter_arb_pkg;

    localparam int unsigned XLEN = 32;
    localparam int unsigned SZW  = 2;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCESS = 2'd1,
        HOLD   = 2'd2
    } arb_state_t;

    typedef enum logic {
        REQ_C = 1'b0,
        REQ_D = 1'b1
    } req_id_t;

    localparam logic [SZW-1:0] SZ_BYTE = 2'd0;
    localparam logic [SZW-1:0] SZ_HALF = 2'd1;
    localparam logic [SZW-1:0] SZ_WORD = 2'd2;

    // One latched port-2 transaction.
    typedef struct packed {
        logic            we;
        logic [XLEN-1:0] addr;
        logic [XLEN-1:0] din;
        logic [SZW-1:0]  size;
        logic            sign;
    } mem_req_t;

    // Access width in bytes; the reserved encoding reports zero.
    function automatic logic [2:0] size_bytes(input logic [SZW-1:0] sz);
        logic [2:0] n;
        n = 3'd0;
        if (sz == SZ_BYTE) n = 3'd1;
        if (sz == SZ_HALF) n = 3'd2;
        if (sz == SZ_WORD) n = 3'd4;
        return n;
    endfunction

endpackage

// File: rtl/otter_dmem_arbiter_if.sv
// Requester handshakes plus the shared OTTER memory port 2.
interface otter_dmem_arbiter_if import otter_arb_pkg::*; ;

    logic            C_REQ, C_WE, C_SIGN;
    logic [XLEN-1:0] C_ADDR, C_DIN;
    logic [SZW-1:0]  C_SIZE;
    logic            D_REQ, D_WE, D_SIGN;
    logic [XLEN-1:0] D_ADDR, D_DIN;
    logic [SZW-1:0]  D_SIZE;

    logic            C_DONE, D_DONE, ARB_BUSY;
    logic [XLEN-1:0] ARB_RDATA;

    logic            MEM_RDEN2, MEM_WE2, MEM_SIGN;
    logic [XLEN-1:0] MEM_ADDR2, MEM_DIN2, MEM_DOUT2;
    logic [SZW-1:0]  MEM_SIZE;

    // Requesters and the memory model side.
    modport master (
        output C_REQ, C_WE, C_ADDR, C_DIN, C_SIZE, C_SIGN,
        output D_REQ, D_WE, D_ADDR, D_DIN, D_SIZE, D_SIGN,
        input  C_DONE, D_DONE, ARB_RDATA, ARB_BUSY,
        input  MEM_RDEN2, MEM_WE2, MEM_ADDR2, MEM_DIN2, MEM_SIZE, MEM_SIGN,
        output MEM_DOUT2
    );

    // Arbiter side.
    modport slave (
        input  C_REQ, C_WE, C_ADDR, C_DIN, C_SIZE, C_SIGN,
        input  D_REQ, D_WE, D_ADDR, D_DIN, D_SIZE, D_SIGN,
        output C_DONE, D_DONE, ARB_RDATA, ARB_BUSY,
        output MEM_RDEN2, MEM_WE2, MEM_ADDR2, MEM_DIN2, MEM_SIZE, MEM_SIGN,
        input  MEM_DOUT2
    );

endinterface

// File: rtl/otter_dmem_arbiter_rr2.sv
// Two-way combinational picker: round-robin on ties, or C-first when fixed priority is set.
module arb_rr2 import otter_arb_pkg::*; (
    input  logic    i_elig_c,
    input  logic    i_elig_d,
    input  req_id_t i_last,
    input  logic    i_fixed_prio,
    output req_id_t o_grant_id_c,
    output logic    o_grant_vld_c
);

    always_comb begin
        o_grant_vld_c = i_elig_c | i_elig_d;
        o_grant_id_c  = REQ_C;
        if (i_elig_c && i_elig_d) begin
            o_grant_id_c = (i_fixed_prio || (i_last == REQ_D)) ? REQ_C : REQ_D;
        end else if (i_elig_d) begin
            o_grant_id_c = REQ_D;
        end
    end

endmodule

// File: rtl/otter_dmem_arbiter.sv
// Shares OTTER memory port 2 between the load/store unit (C) and a DMA/debug master (D).
// Port fields are registered and held through HOLD so combinational read sizing sees a stable address.
module otter_dmem_arbiter import otter_arb_pkg::*; #(
    parameter bit FIXED_PRIO = 1'b0
) (
    input  logic                 ARB_CLK,
    input  logic                 ARB_RST_N,
    otter_dmem_arbiter_if.slave  bus
);

    arb_state_t      r_state, w_state_nxt;
    req_id_t         r_last, w_last_nxt;
    req_id_t         r_id, w_id_nxt;
    req_id_t         w_grant_id;
    logic            w_grant_vld;
    logic            w_c_elig, w_d_elig;
    mem_req_t        r_req, w_req_nxt;
    mem_req_t        w_c_fields, w_d_fields;
    logic            r_we, w_we_nxt;
    logic            r_rden, w_rden_nxt;
    logic            r_c_done, w_c_done_nxt;
    logic            r_d_done, w_d_done_nxt;
    logic            r_busy;
    logic [XLEN-1:0] r_rdata, w_rdata_nxt;

    // A requester whose DONE is high this cycle is still showing its old REQ.
    assign w_c_elig = bus.C_REQ & ~r_c_done;
    assign w_d_elig = bus.D_REQ & ~r_d_done;

    assign w_c_fields = '{we: bus.C_WE, addr: bus.C_ADDR, din: bus.C_DIN,
                          size: bus.C_SIZE, sign: bus.C_SIGN};
    assign w_d_fields = '{we: bus.D_WE, addr: bus.D_ADDR, din: bus.D_DIN,
                          size: bus.D_SIZE, sign: bus.D_SIGN};

    arb_rr2 u_rr2 (
        .i_elig_c      (w_c_elig),
        .i_elig_d      (w_d_elig),
        .i_last        (r_last),
        .i_fixed_prio  (FIXED_PRIO),
        .o_grant_id_c  (w_grant_id),
        .o_grant_vld_c (w_grant_vld)
    );

    always_comb begin
        w_state_nxt  = r_state;
        w_last_nxt   = r_last;
        w_id_nxt     = r_id;
        w_req_nxt    = r_req;
        w_we_nxt     = 1'b0;
        w_rden_nxt   = 1'b0;
        w_c_done_nxt = 1'b0;
        w_d_done_nxt = 1'b0;
        w_rdata_nxt  = r_rdata;
        unique case (r_state)
            IDLE: begin
                if (w_grant_vld) begin
                    w_state_nxt = ACCESS;
                    w_id_nxt    = w_grant_id;
                    w_last_nxt  = w_grant_id;
                    w_req_nxt   = (w_grant_id == REQ_C) ? w_c_fields : w_d_fields;
                    w_we_nxt    = w_req_nxt.we;
                    w_rden_nxt  = ~w_req_nxt.we;
                end
            end
            ACCESS: begin
                if (r_req.we) begin
                    w_state_nxt  = IDLE;
                    w_c_done_nxt = (r_id == REQ_C);
                    w_d_done_nxt = (r_id == REQ_D);
                end else begin
                    w_state_nxt = HOLD;
                end
            end
            HOLD: begin
                w_state_nxt  = IDLE;
                w_rdata_nxt  = bus.MEM_DOUT2;
                w_c_done_nxt = (r_id == REQ_C);
                w_d_done_nxt = (r_id == REQ_D);
            end
            default: w_state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge ARB_CLK or negedge ARB_RST_N) begin
        if (!ARB_RST_N) begin
            r_state  <= IDLE;
            r_last   <= REQ_D;
            r_id     <= REQ_C;
            r_req    <= '{we: 1'b0, addr: '0, din: '0, size: SZ_BYTE, sign: 1'b0};
            r_we     <= 1'b0;
            r_rden   <= 1'b0;
            r_c_done <= 1'b0;
            r_d_done <= 1'b0;
            r_busy   <= 1'b0;
            r_rdata  <= '0;
        end else begin
            r_state  <= w_state_nxt;
            r_last   <= w_last_nxt;
            r_id     <= w_id_nxt;
            r_req    <= w_req_nxt;
            r_we     <= w_we_nxt;
            r_rden   <= w_rden_nxt;
            r_c_done <= w_c_done_nxt;
            r_d_done <= w_d_done_nxt;
            r_busy   <= (w_state_nxt != IDLE);
            r_rdata  <= w_rdata_nxt;
        end
    end

    assign bus.MEM_WE2   = r_we;
    assign bus.MEM_RDEN2 = r_rden;
    assign bus.MEM_ADDR2 = r_req.addr;
    assign bus.MEM_DIN2  = r_req.din;
    assign bus.MEM_SIZE  = r_req.size;
    assign bus.MEM_SIGN  = r_req.sign;
    assign bus.C_DONE    = r_c_done;
    assign bus.D_DONE    = r_d_done;
    assign bus.ARB_BUSY  = r_busy;
    assign bus.ARB_RDATA = r_rdata;

endmodule

// File: tb/tb_otter_dmem_arbiter.sv
// Scoreboard bench: a round-robin arbiter on a BRAM model and a fixed-priority one on an address-echo model.
module tb_otter_dmem_arbiter;
    import otter_arb_pkg::*;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    otter_dmem_arbiter_if bus0();
    otter_dmem_arbiter_if bus1();

    otter_dmem_arbiter #(.FIXED_PRIO(1'b0)) u_dut_rr (.ARB_CLK(clk), .ARB_RST_N(rst_n), .bus(bus0.slave));
    otter_dmem_arbiter #(.FIXED_PRIO(1'b1)) u_dut_fp (.ARB_CLK(clk), .ARB_RST_N(rst_n), .bus(bus1.slave));

    typedef struct { logic id; logic is_load; logic [31:0] rdata; } exp_t;
    exp_t q0[$];
    exp_t q1[$];
    int n_cmp = 0;
    int n_bad = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h want %h", name, act, exp);
        end
    endtask

    function automatic exp_t mk(input logic id, input logic ld, input logic [31:0] d);
        exp_t e;
        e.id = id; e.is_load = ld; e.rdata = d;
        return e;
    endfunction

    // OTTER-style memory: raw word registered on RDEN2, sizing applied on the live address.
    function automatic logic [31:0] sized(input logic [31:0] w, input logic [1:0] a,
                                          input logic [1:0] sz, input logic uns);
        logic [7:0]  b;
        logic [15:0] h;
        b = w[int'(a)*8 +: 8];
        h = w[int'(a[1])*16 +: 16];
        case (sz)
            2'd0:    return uns ? {24'h0, b} : {{24{b[7]}}, b};
            2'd1:    return uns ? {16'h0, h} : {{16{h[15]}}, h};
            2'd2:    return w;
            default: return 32'h0;
        endcase
    endfunction

    logic [31:0] mem [0:1023];
    logic [31:0] r_word0;
    logic        bd_we = 1'b0;
    logic [31:0] bd_addr = 32'h0;
    logic [31:0] bd_data = 32'h0;

    always @(posedge clk) begin
        if (bd_we) begin
            mem[bd_addr[11:2]] <= bd_data;
        end else if (bus0.MEM_WE2 && bus0.MEM_ADDR2 < 32'h1_0000) begin
            case (bus0.MEM_SIZE)
                2'd0: mem[bus0.MEM_ADDR2[11:2]][int'(bus0.MEM_ADDR2[1:0])*8 +: 8] <= bus0.MEM_DIN2[7:0];
                2'd1: mem[bus0.MEM_ADDR2[11:2]][int'(bus0.MEM_ADDR2[1])*16 +: 16] <= bus0.MEM_DIN2[15:0];
                2'd2: mem[bus0.MEM_ADDR2[11:2]] <= bus0.MEM_DIN2;
                default: ;
            endcase
        end
        if (bus0.MEM_RDEN2)
            r_word0 <= (bus0.MEM_ADDR2 < 32'h1_0000) ? mem[bus0.MEM_ADDR2[11:2]] : 32'h0;
    end
    assign bus0.MEM_DOUT2 = sized(r_word0, bus0.MEM_ADDR2[1:0], bus0.MEM_SIZE, bus0.MEM_SIGN);

    logic [31:0] r_word1;
    always @(posedge clk) if (bus1.MEM_RDEN2) r_word1 <= bus1.MEM_ADDR2 ^ 32'h5A5A_0000;
    assign bus1.MEM_DOUT2 = r_word1;

    // Monitors: every DONE pops the next expected completion.
    always @(negedge clk) begin : mon_rr
        exp_t e;
        if (rst_n && (bus0.C_DONE || bus0.D_DONE)) begin
            if (q0.size() == 0) begin
                n_cmp++; n_bad++;
                $display("FAIL rr_unexpected_done: got c=%b d=%b want no DONE", bus0.C_DONE, bus0.D_DONE);
            end else begin
                e = q0.pop_front();
                chk("rr_done_id", 32'({bus0.C_DONE, bus0.D_DONE}), e.id ? 32'd1 : 32'd2);
                if (e.is_load) chk("rr_rdata", bus0.ARB_RDATA, e.rdata);
            end
        end
    end

    always @(negedge clk) begin : mon_fp
        exp_t e;
        if (rst_n && (bus1.C_DONE || bus1.D_DONE)) begin
            if (q1.size() == 0) begin
                n_cmp++; n_bad++;
                $display("FAIL fp_unexpected_done: got c=%b d=%b want no DONE", bus1.C_DONE, bus1.D_DONE);
            end else begin
                e = q1.pop_front();
                chk("fp_done_id", 32'({bus1.C_DONE, bus1.D_DONE}), e.id ? 32'd1 : 32'd2);
                if (e.is_load) chk("fp_rdata", bus1.ARB_RDATA, e.rdata);
            end
        end
    end

    task automatic set_req(input int inst, input logic id, input logic req, input logic we,
                           input logic [31:0] addr, input logic [31:0] din,
                           input logic [1:0] size, input logic sign);
        if (inst == 0 && id == 1'b0) begin
            bus0.C_REQ = req; bus0.C_WE = we; bus0.C_ADDR = addr;
            bus0.C_DIN = din; bus0.C_SIZE = size; bus0.C_SIGN = sign;
        end else if (inst == 0) begin
            bus0.D_REQ = req; bus0.D_WE = we; bus0.D_ADDR = addr;
            bus0.D_DIN = din; bus0.D_SIZE = size; bus0.D_SIGN = sign;
        end else if (id == 1'b0) begin
            bus1.C_REQ = req; bus1.C_WE = we; bus1.C_ADDR = addr;
            bus1.C_DIN = din; bus1.C_SIZE = size; bus1.C_SIGN = sign;
        end else begin
            bus1.D_REQ = req; bus1.D_WE = we; bus1.D_ADDR = addr;
            bus1.D_DIN = din; bus1.D_SIZE = size; bus1.D_SIGN = sign;
        end
    endtask

    function automatic logic get_done(input int inst, input logic id);
        if (inst == 0) return id ? bus0.D_DONE : bus0.C_DONE;
        return id ? bus1.D_DONE : bus1.C_DONE;
    endfunction

    task automatic poke(input logic [31:0] a, input logic [31:0] d);
        @(posedge clk); #1;
        bd_addr = a; bd_data = d; bd_we = 1'b1;
        @(posedge clk); #1;
        bd_we = 1'b0;
    endtask

    // Single uncontested transfer on the round-robin instance, with port observations.
    task automatic xfer(input logic id, input logic we, input logic [31:0] addr, input logic [31:0] din,
                        input logic [1:0] size, input logic sign,
                        output int lat, output int we_cyc, output int rd_cyc, output logic stable);
        lat = -1; we_cyc = 0; rd_cyc = 0; stable = 1'b1;
        @(posedge clk); #1;
        set_req(0, id, 1'b1, we, addr, din, size, sign);
        for (int k = 0; k < 40; k++) begin
            @(negedge clk);
            if (bus0.MEM_WE2) we_cyc++;
            if (bus0.MEM_RDEN2) rd_cyc++;
            if (bus0.ARB_BUSY && (bus0.MEM_ADDR2 !== addr || bus0.MEM_SIZE !== size || bus0.MEM_SIGN !== sign))
                stable = 1'b0;
            if (get_done(0, id)) begin
                lat = k;
                break;
            end
        end
        set_req(0, id, 1'b0, we, addr, din, size, sign);
        if (lat < 0) begin
            n_cmp++; n_bad++;
            $display("FAIL xfer_timeout: id %0d got no DONE want DONE within 40 cycles", id);
        end
    endtask

    // Word loads from consecutive addresses with REQ held high across DONE.
    task automatic stream(input int inst, input logic id, input int n, input logic [31:0] base);
        int got = 0;
        @(posedge clk); #1;
        set_req(inst, id, 1'b1, 1'b0, base, 32'h0, SZ_WORD, 1'b0);
        for (int k = 0; k < 200 && got < n; k++) begin
            @(negedge clk);
            if (get_done(inst, id)) begin
                got++;
                set_req(inst, id, (got < n), 1'b0, base + 32'(4 * got), 32'h0, SZ_WORD, 1'b0);
            end
        end
        if (got < n) begin
            set_req(inst, id, 1'b0, 1'b0, base, 32'h0, SZ_WORD, 1'b0);
            n_cmp++; n_bad++;
            $display("FAIL stream_timeout: inst %0d id %0d got %0d DONEs want %0d", inst, id, got, n);
        end
    endtask

    initial begin
        #60000;
        $display("FAIL watchdog: got no end of test want completion before 60000");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int   lat, wc, rc;
        logic st;
        for (int i = 0; i < 2; i++) begin
            set_req(i, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 2'd0, 1'b0);
            set_req(i, 1'b1, 1'b0, 1'b0, 32'h0, 32'h0, 2'd0, 1'b0);
        end
        poke(32'h100, 32'hDEAD_BEEF); poke(32'h200, 32'h0); poke(32'h004, 32'h0); poke(32'h500, 32'h0);
        poke(32'h300, 32'h1111_1111); poke(32'h304, 32'h2222_2222); poke(32'h308, 32'h3333_3333);
        poke(32'h400, 32'h4444_4444); poke(32'h404, 32'h5555_5555); poke(32'h408, 32'h6666_6666);
        @(posedge clk); #1;
        rst_n = 1'b1;
        #1;
        chk("rst_ctl", 32'({bus0.ARB_BUSY, bus0.C_DONE, bus0.D_DONE, bus0.MEM_WE2,
                            bus0.MEM_RDEN2, bus0.MEM_SIGN, bus0.MEM_SIZE}), 32'h0);
        chk("rst_addr", bus0.MEM_ADDR2, 32'h0);
        chk("rst_din", bus0.MEM_DIN2, 32'h0);
        chk("rst_rdata", bus0.ARB_RDATA, 32'h0);

        // C word load
        q0.push_back(mk(1'b0, 1'b1, 32'hDEAD_BEEF));
        xfer(1'b0, 1'b0, 32'h100, 32'h0, SZ_WORD, 1'b0, lat, wc, rc, st);
        chk("c_load_latency", 32'(lat), 32'd3);
        chk("c_load_rden_cycles", 32'(rc), 32'd1);
        chk("c_load_we_cycles", 32'(wc), 32'd0);
        chk("c_load_port_stable", 32'(st), 32'd1);

        // D byte store, then sized loads of the same word
        q0.push_back(mk(1'b1, 1'b0, 32'h0));
        xfer(1'b1, 1'b1, 32'h203, 32'h0000_00A5, SZ_BYTE, 1'b0, lat, wc, rc, st);
        chk("d_store_latency", 32'(lat), 32'd2);
        chk("d_store_we_cycles", 32'(wc), 32'd1);
        chk("d_store_mem_word", mem[128], 32'hA500_0000);
        chk("rdata_kept_after_store", bus0.ARB_RDATA, 32'hDEAD_BEEF);
        q0.push_back(mk(1'b0, 1'b1, 32'hFFFF_FFA5));
        xfer(1'b0, 1'b0, 32'h203, 32'h0, SZ_BYTE, 1'b0, lat, wc, rc, st);
        chk("c_lb_port_stable", 32'(st), 32'd1);
        q0.push_back(mk(1'b1, 1'b1, 32'h0000_A500));
        xfer(1'b1, 1'b0, 32'h202, 32'h0, SZ_HALF, 1'b1, lat, wc, rc, st);
        chk("d_lhu_latency", 32'(lat), 32'd3);

        // Both held continuously: strict alternation starting with C
        q0.push_back(mk(1'b0, 1'b1, 32'h1111_1111)); q0.push_back(mk(1'b1, 1'b1, 32'h4444_4444));
        q0.push_back(mk(1'b0, 1'b1, 32'h2222_2222)); q0.push_back(mk(1'b1, 1'b1, 32'h5555_5555));
        q0.push_back(mk(1'b0, 1'b1, 32'h3333_3333)); q0.push_back(mk(1'b1, 1'b1, 32'h6666_6666));
        fork
            stream(0, 1'b0, 3, 32'h300);
            stream(0, 1'b1, 3, 32'h400);
        join

        // MMIO store passes through; the array must not alias it
        q0.push_back(mk(1'b1, 1'b0, 32'h0));
        xfer(1'b1, 1'b1, 32'h1_0004, 32'h1234_5678, SZ_WORD, 1'b0, lat, wc, rc, st);
        chk("mmio_latency", 32'(lat), 32'd2);
        chk("mmio_we_cycles", 32'(wc), 32'd1);
        chk("mmio_addr_stable", 32'(st), 32'd1);
        chk("mmio_no_alias", mem[1], 32'h0);

        // Reset during ACCESS of a C store
        @(posedge clk); #1;
        set_req(0, 1'b0, 1'b1, 1'b1, 32'h500, 32'hCAFE_F00D, SZ_WORD, 1'b0);
        @(posedge clk); #2;
        chk("abort_in_access", 32'(bus0.MEM_WE2), 32'd1);
        rst_n = 1'b0;
        #1;
        chk("abort_ctl", 32'({bus0.ARB_BUSY, bus0.C_DONE, bus0.D_DONE, bus0.MEM_WE2,
                              bus0.MEM_RDEN2, bus0.MEM_SIGN, bus0.MEM_SIZE}), 32'h0);
        chk("abort_addr", bus0.MEM_ADDR2, 32'h0);
        chk("abort_rdata", bus0.ARB_RDATA, 32'h0);
        set_req(0, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 2'd0, 1'b0);
        repeat (3) @(posedge clk);
        #1;
        rst_n = 1'b1;
        chk("abort_mem_untouched", mem[320], 32'h0);
        q0.push_back(mk(1'b0, 1'b1, 32'hDEAD_BEEF));
        xfer(1'b0, 1'b0, 32'h100, 32'h0, SZ_WORD, 1'b0, lat, wc, rc, st);
        chk("post_reset_latency", 32'(lat), 32'd3);

        // Fixed priority: C wins a tie even when it was granted last
        q1.push_back(mk(1'b0, 1'b1, 32'h5A5A_0010));
        stream(1, 1'b0, 1, 32'h10);
        q1.push_back(mk(1'b0, 1'b1, 32'h5A5A_0020));
        q1.push_back(mk(1'b1, 1'b1, 32'h5A5A_0040));
        fork
            stream(1, 1'b0, 1, 32'h20);
            stream(1, 1'b1, 1, 32'h40);
        join

        repeat (4) @(posedge clk);
        #1;
        chk("rr_queue_drained", 32'(q0.size()), 32'd0);
        chk("fp_queue_drained", 32'(q1.size()), 32'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
